// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets NUM_REQ requesters share one UART TX line.
// One frame = start bit, DATA_WIDTH data bits LSB-first, stop bit; bits advance on baud ticks.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             baud,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state;
  logic [IdW-1:0]        last_grant;
  logic [IdW-1:0]        winner;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [BitW-1:0]       bit_idx;
  logic                  found;
  logic                  grant;
  int unsigned           idx;

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  // The stop-ending tick doubles as a grant slot so frames can run back-to-back.
  assign grant = !rst && baud && found && (state == StIdle || state == StStop);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  assign busy      = (state != StIdle);
  assign shreg_nxt = shreg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      tx         <= 1'b1;
      grant_id   <= '0;
      last_grant <= IdW'(NUM_REQ - 1);
      shreg      <= '0;
      bit_idx    <= '0;
    end else if (grant) begin
      state      <= StStart;
      tx         <= 1'b0;
      shreg      <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
      grant_id   <= winner;
      last_grant <= winner;
      bit_idx    <= '0;
    end else if (baud) begin
      unique case (state)
        StStart: begin
          state   <= StData;
          tx      <= shreg[0];
          bit_idx <= '0;
        end
        StData: begin
          if (bit_idx == BitW'(DATA_WIDTH - 1)) begin
            state <= StStop;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg_nxt;
            tx      <= shreg_nxt[0];
          end
        end
        StStop: begin
          state <= StIdle;
          tx    <= 1'b1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: scenario tasks plus randomized traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              baud;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              tx;
  logic              busy;
  logic [GW-1:0]     grant_id;

  uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud      (baud),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is a list of DW+2 line levels; m_left counts baud ticks still owed.
  int            m_left;
  int            m_idx;
  logic          m_tx;
  logic [GW-1:0] m_gid;
  logic [GW-1:0] m_last;
  logic [DW+1:0] m_frame;

  int   grants[$];
  bit   b2b[$];
  logic tx_log[$];

  int bdiv = 16;
  int cnt  = 0;
  bit hold_valid = 0;
  bit rand_req   = 0;

  task automatic model_reset();
    m_left = 0; m_idx = 0; m_tx = 1'b1; m_gid = '0; m_last = GW'(N - 1); m_frame = '0;
  endtask

  function automatic int rr_pick();
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (int'(m_last) + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!rst && baud && m_left <= 1 && req_valid != '0) r[rr_pick()] = 1'b1;
    return r;
  endfunction

  task automatic model_step(output int w);
    w = -1;
    if (rst) begin
      model_reset();
    end else if (baud) begin
      if (m_left <= 1 && req_valid != '0) begin
        w = rr_pick();
        grants.push_back(w);
        b2b.push_back(m_left == 1);
        m_last  = GW'(w);
        m_gid   = GW'(w);
        m_frame = {1'b1, req_data[w*DW +: DW], 1'b0};
        m_left  = DW + 2;
        m_idx   = 0;
        m_tx    = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        m_idx++;
        m_tx = (m_left == 0) ? 1'b1 : m_frame[m_idx];
      end
    end
  endtask

  // Drives n cycles of baud/requests and compares every observable output against the model.
  task automatic run(input int n);
    logic [N-1:0] er;
    int w;
    for (int c = 0; c < n; c++) begin
      if (bdiv == 0) baud = ($urandom_range(0, 2) == 0);
      else begin
        baud = (cnt == bdiv - 1);
        cnt  = (cnt + 1) % bdiv;
      end
      @(negedge clk);
      er = exp_ready();
      n_tests++;
      if (req_ready !== er) begin
        n_fail++; $display("FAIL req_ready t=%0t got %b want %b", $time, req_ready, er);
      end
      n_tests++;
      if (tx !== m_tx) begin
        n_fail++; $display("FAIL tx t=%0t got %b want %b", $time, tx, m_tx);
      end
      n_tests++;
      if (busy !== (m_left != 0)) begin
        n_fail++; $display("FAIL busy t=%0t got %b want %b", $time, busy, m_left != 0);
      end
      n_tests++;
      if (grant_id !== m_gid) begin
        n_fail++; $display("FAIL grant_id t=%0t got %0d want %0d", $time, grant_id, m_gid);
      end
      if (baud) tx_log.push_back(tx);
      model_step(w);
      @(posedge clk); #1;
      if (w >= 0 && !hold_valid) req_valid[w] = 1'b0;
      if (rand_req)
        for (int i = 0; i < N; i++)
          if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
            req_data[i*DW +: DW] = DW'($urandom);
            req_valid[i] = 1'b1;
          end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; baud = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0; cnt = 0; bdiv = 16; hold_valid = 0; rand_req = 0;
    model_reset();
    grants.delete(); b2b.delete(); tx_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; baud = 1'b1; req_valid = '1; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++;
    if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_overrides_baud got %b want 0000", req_ready);
    end
    cnt = 15;
    run(1);
    rst = 1'b0; req_valid = '0; cnt = 0;
  endtask

  task automatic test_single();
    logic [9:0] wave;
    wave = 10'b1101001010;
    do_reset();
    req_data[0 +: DW] = 8'hA5;
    req_valid = 4'b0001;
    run(11 * 16);
    n_tests++;
    if (grants.size() != 1 || grants[0] != 0) begin
      n_fail++; $display("FAIL single_grant got %0d grants want one to requester 0", grants.size());
    end
    n_tests++;
    if (tx_log.size() < 11) begin
      n_fail++; $display("FAIL single_ticks got %0d want 11", tx_log.size());
    end else
      for (int k = 1; k <= 10; k++) begin
        n_tests++;
        if (tx_log[k] !== wave[k-1]) begin
          n_fail++; $display("FAIL single_wave bit%0d got %b want %b", k - 1, tx_log[k], wave[k-1]);
        end
      end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    hold_valid = 1;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    req_valid = 4'b1111;
    run(41 * 16);
    n_tests++;
    if (grants.size() < 5) begin
      n_fail++; $display("FAIL rr_count got %0d want 5", grants.size());
    end else
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (grants[k] != exp_order[k] || (k > 0 && !b2b[k])) begin
          n_fail++;
          $display("FAIL rr_order idx%0d got %0d (b2b %0d) want %0d (b2b 1)",
                   k, grants[k], b2b[k], exp_order[k]);
        end
      end
    hold_valid = 0; req_valid = '0;
    run(11 * 16);
  endtask

  task automatic test_skip_wrap();
    do_reset();
    req_data = N*DW'($urandom);
    req_valid = 4'b0100;
    run(11 * 16);
    grants.delete();
    req_valid = 4'b0011;
    run(21 * 16);
    n_tests++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      n_fail++; $display("FAIL skip_wrap got %0d grants first %0d want 0 then 1",
                         grants.size(), grants.size() > 0 ? grants[0] : -1);
    end
    n_tests++;
    if (grant_id !== 2'd1) begin n_fail++; $display("FAIL skip_wrap_id got %0d want 1", grant_id); end
  endtask

  task automatic test_no_tick();
    do_reset();
    req_data[3*DW +: DW] = DW'($urandom);
    req_valid = 4'b1000;
    run(15);
    n_tests++;
    if (grants.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_tick_early busy %b want 0", busy);
    end
    run(1);
    n_tests++;
    if (grant_id !== 2'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL no_tick_grant got id %0d busy %b want id 3 busy 1", grant_id, busy);
    end
    run(10 * 16);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[1*DW +: DW] = 8'h00;
    req_valid = 4'b0010;
    run(88);
    n_tests++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3 got %b want 0", tx); end
    rst = 1'b1; cnt = 15;
    req_data[0 +: DW] = DW'($urandom);
    req_data[2*DW +: DW] = DW'($urandom);
    req_valid = 4'b0101;
    run(1);
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || grant_id !== '0) begin
      n_fail++; $display("FAIL mid_reset got tx %b busy %b id %0d want 1 0 0", tx, busy, grant_id);
    end
    rst = 1'b0; cnt = 0;
    grants.delete();
    run(16);
    n_tests++;
    if (grants.size() != 1 || grants[0] != 0) begin
      n_fail++; $display("FAIL mid_next_grant got %0d grants want requester 0", grants.size());
    end
    run(21 * 16);
  endtask

  task automatic test_late_request();
    do_reset();
    req_data[1*DW +: DW] = DW'($urandom);
    req_valid = 4'b0010;
    run(16);
    run(5 * 16);
    req_data[2*DW +: DW] = DW'($urandom);
    req_valid[2] = 1'b1;
    grants.delete(); b2b.delete();
    run(10 * 16);
    n_tests++;
    if (grants.size() != 1 || grants[0] != 2 || !b2b[0]) begin
      n_fail++; $display("FAIL late_request got %0d grants want one back-to-back to 2", grants.size());
    end
    run(10 * 16);
  endtask

  task automatic test_random();
    do_reset();
    bdiv = 0; rand_req = 1;
    run(4000);
    rand_req = 0;
    run(2000);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL random_drain busy got %b want 0", busy); end
    bdiv = 16; cnt = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_no_tick();
    test_reset_mid();
    test_late_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the TX line (range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port baud  input  1  one-clk bit-period tick from the baud generator.
REQ-006 SHALL have port req_valid  input  NUM_REQ  bit i: requester i offers a byte.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  bit i: byte of requester i accepted this cycle.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester most recently granted.

Function
REQ-012 SHALL sequence states IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-013 SHALL only change state on baud=1 cycles; no state change on baud=0.
REQ-014 SHALL grant only in IDLE, or in STOP on a baud=1 cycle; only on a baud=1 cycle with at least one req_valid bit set.
REQ-015 SHALL pick the winner round-robin: search starts at (last_grant+1) mod NUM_REQ, wrapping; first set req_valid wins.
REQ-016 SHALL assert req_ready one-hot for the winner, combinationally, in the grant cycle only; transfer = req_valid[i] & req_ready[i].
REQ-017 SHALL, on transfer, latch winner data into a shift register, update grant_id and last_grant, and enter START at the next edge.
REQ-018 SHALL drive tx=0 in START, the data bit LSB-first in DATA, and tx=1 in STOP and IDLE.
REQ-019 SHALL change tx on the clock edge following the grant or baud tick; each bit lasts exactly one baud period.
REQ-020 SHALL move START->DATA on baud with bit index 0; DATA shifts on each baud; DATA->STOP on the baud ending bit DATA_WIDTH-1.
REQ-021 SHALL end STOP on baud: grant a new winner if any req_valid (back-to-back frames, no idle gap), else go to IDLE.
REQ-022 SHALL keep a frame at exactly DATA_WIDTH+2 baud periods (10 for default).
REQ-023 SHALL ignore req_valid changes and req_data during a frame; requesters hold valid and data stable until req_ready.
REQ-024 SHALL never assert more than one req_ready bit, and none while busy outside the STOP-final baud cycle.
REQ-025 SHALL hold grant_id after a frame until the next grant.

Reset
REQ-026 SHALL on rst: state IDLE, tx=1, busy=0, req_ready=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 highest priority), shift register and bit index 0.
REQ-027 SHALL on rst mid-frame abort the frame: tx=1 at the next edge, no req_ready, no pending grant retained.
REQ-028 SHALL have rst override a simultaneous baud and req_valid.

Verification
REQ-029 SHALL cover single frame: req_valid=0001, data 0xA5, baud every 16 clk -> req_ready[0] on first baud; tx = 0,1,0,1,0,0,1,0,1,1 per period; busy low after 10 periods.
REQ-030 SHALL cover round-robin: req_valid=1111 held -> grants 0,1,2,3,0 in order; frames back-to-back with no idle-high gap beyond stop bit.
REQ-031 SHALL cover skip and wrap: last_grant=2, req_valid=0011 -> grant 0 then 1; grant_id=0 then 1.
REQ-032 SHALL cover no-tick grant: req_valid asserted with baud=0 -> req_ready stays 0 until the next baud cycle.
REQ-033 SHALL cover reset mid-frame: rst during bit 3 of 0x00 -> tx=1 next edge, busy=0, grant_id=0; next grant goes to requester 0.
REQ-034 SHALL cover late request: req_valid[2] asserted mid-frame of requester 1 -> req_ready[2] exactly on the STOP-ending baud; start bit follows immediately.
